// File: rtl/f_d_fetch_queue_pkg.sv
// Shared fetch/decode types and constants: the 64-bit fetch pair and reset/NOP encodings.
// No logic; imported by the queue, its storage and the interface users.
package f_d_fetch_queue_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // pc occupies [63:32], instr [31:0]
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pair_t;

endpackage

// File: rtl/f_d_fetch_queue_if.sv
// Fetch-to-decode queue signal bundle: push side, pop side, flush and occupancy status.
// master = the environment driving the queue, slave = the queue itself.
interface f_d_fetch_queue_if #(
  parameter int PTR_W = 2
);

  logic             push_valid;
  logic [31:0]      push_pc;
  logic [31:0]      push_instr;
  logic             push_ready;
  logic             pop_valid;
  logic             pop_ready;
  logic [31:0]      pop_pc;
  logic [31:0]      pop_instr;
  logic             flush;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;

  modport master (
    output push_valid, push_pc, push_instr, pop_ready, flush,
    input  push_ready, pop_valid, pop_pc, pop_instr, count, full, empty
  );

  modport slave (
    input  push_valid, push_pc, push_instr, pop_ready, flush,
    output push_ready, pop_valid, pop_pc, pop_instr, count, full, empty
  );

endinterface

// File: rtl/f_d_queue_ram.sv
// DEPTH x 64 fetch-pair storage: synchronous write, asynchronous read, contents never reset.
// Write lands on the clock edge; read is combinational from raddr; no backpressure.
module f_d_queue_ram
  import f_d_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  fetch_pair_t       wdata,
  input  logic [PTR_W-1:0]  raddr,
  output fetch_pair_t       rdata
);

  fetch_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/f_d_fetch_queue.sv
// Circular fetch->decode queue; 1-cycle push-to-pop latency, no empty or full bypass.
// push_ready depends on occupancy only, so fetch stalls only when full; flush drops everything.
module f_d_fetch_queue
  import f_d_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  f_d_fetch_queue_if.slave    q
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_q;
  logic             full_w;
  logic             empty_w;
  logic             pop_valid_w;
  logic             push_fire;
  logic             pop_fire;
  fetch_pair_t      wr_pair;
  fetch_pair_t      rd_pair;

  assign full_w      = (count_q == FULL_CNT);
  assign empty_w     = (count_q == '0);
  assign pop_valid_w = !empty_w && !q.flush;
  assign push_fire   = q.push_valid && !full_w && !q.flush;
  assign pop_fire    = pop_valid_w && q.pop_ready;

  assign wr_pair.pc    = q.push_pc;
  assign wr_pair.instr = q.push_instr;

  f_d_queue_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push_fire),
    .waddr (wr_ptr),
    .wdata (wr_pair),
    .raddr (rd_ptr),
    .rdata (rd_pair)
  );

  // Pointers wrap naturally at PTR_W bits; a simultaneous push and pop leaves count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_fire, pop_fire})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Decode sees a NOP whenever nothing valid is presented.
  assign q.pop_valid  = pop_valid_w;
  assign q.pop_pc     = pop_valid_w ? rd_pair.pc    : 32'h0000_0000;
  assign q.pop_instr  = pop_valid_w ? rd_pair.instr : NOP_INSTR;
  assign q.push_ready = !full_w;
  assign q.count      = count_q;
  assign q.full       = full_w;
  assign q.empty      = empty_w;

endmodule

// File: doc/f_d_fetch_queue.md
Name: f_d_fetch_queue

Overview:
- Small circular instruction queue between the fetch stage and the decode stage.
- Absorbs the (PC, instruction) pair produced each cycle by the PC register and instruction memory. Hands pairs to decode under a valid/ready handshake.
- push_ready drives the PC register's enable, so fetch stalls only when the queue is full, not on every decode stall.
- flush discards all buffered fetches on a redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- push_valid  input  1  fetch stage offers a pair this cycle
- push_pc  input  32  PC of the offered instruction
- push_instr  input  32  instruction word at push_pc
- push_ready  output  1  queue can accept; wired to the PC register enable
- pop_valid  output  1  head entry available to decode
- pop_ready  input  1  decode consumes the head this cycle (low when decode stalls)
- pop_pc  output  32  PC of head entry
- pop_instr  output  32  instruction of head entry
- flush  input  1  discard all entries and any push this cycle
- count  output  PTR_W+1  current occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- State: storage array of DEPTH x 64 bits, rd_ptr, wr_ptr (PTR_W bits each), count (PTR_W+1 bits).
- Reset (async, any time, including mid-operation): rd_ptr=0, wr_ptr=0, count=0 immediately.
  - Resulting outputs: pop_valid=0, pop_pc=0, pop_instr=0, push_ready=1, full=0, empty=1.
  - Storage contents are not cleared.
- push_ready = !full. It is combinational from count only and has no path from pop_ready. There is no full-queue bypass: a push into a full queue is not accepted, even if a pop occurs in the same cycle.
- pop_valid = !empty && !flush.
- pop_pc and pop_instr show the head entry when pop_valid=1. Both are forced to 32'h0000_0000 (NOP) when pop_valid=0.
- push_fire = push_valid && push_ready && !flush.
- pop_fire = pop_valid && pop_ready.
- On each rising edge, if flush=1:
  - rd_ptr=wr_ptr=0, count=0.
  - Push and pop of that cycle are discarded.
  - The decode-side delay-slot policy is handled by the redirect source, not here.
- On each rising edge, if flush=0:
  - push_fire only: write mem[wr_ptr], wr_ptr+1, count+1.
  - pop_fire only: rd_ptr+1, count-1.
  - Both: write and read in the same edge, count unchanged. Legal whenever 0 < count < DEPTH.
  - Neither: hold.
- Pointers wrap modulo DEPTH (natural PTR_W-bit overflow).
- Latency: an entry pushed into an empty queue is visible on pop_* one cycle later. There is no empty-queue bypass.
- Ordering: strict FIFO; pairs exit in push order.
- count, full and empty are registered-derived and combinational from count.
- Never-happens checks for the bench: count > DEPTH; pop_fire while empty; push_fire while full.

Decomposition:
- Shared package constants: PC_RESET = 32'h0000_3000, NOP_INSTR = 32'h0000_0000. Fetch-pair struct width = 64 (pc in [63:32], instr in [31:0]).
- One natural sub-module: f_d_queue_ram, a DEPTH x 64 register array.
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
  - No reset on contents.
- Pointer, count and handshake logic stay in f_d_fetch_queue.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset mid-cycle with count=3.
  - Response: within the same cycle, count=0, empty=1, pop_valid=0, pop_pc=0, push_ready=1.
- Fill to full:
  - Stimulus: pop_ready=0; push PCs 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles.
  - Response: after the 4th edge full=1, push_ready=0. A 5th push of 0x3010 is not accepted; count stays 4.
- Drain in order:
  - Stimulus: from full, pop_ready=1, push_valid=0.
  - Response: pop_pc sequence 0x3000, 0x3004, 0x3008, 0x300C over 4 cycles, then pop_valid=0 and pop_pc=0.
- Simultaneous push/pop with wrap-around:
  - Stimulus: count=2, 10 cycles of push and pop together.
  - Response: count stays 2; pointers wrap past 3 to 0; output order matches input order exactly.
- Flush:
  - Stimulus: count=3, flush=1 together with push_valid=1 (pc 0x4000).
  - Response: pop_valid=0 during the flush cycle; after the edge count=0. The 0x4000 pair is absent; the next push appears alone.
- Empty latency:
  - Stimulus: empty queue, single push of pc 0x3020 / instr 0x2408_0001.
  - Response: pop_valid=0 in the push cycle; pop_valid=1 with those values exactly one cycle later.
